// File: rtl/mem_access_unit.sv
// Load/store controller for a word-wide single-port synchronous data memory.
// Optional misalignment error reporting: define MAU_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int MEM_LATENCY = 1,
  parameter int WORD_SHIFT  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  offset_q, offset_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        req_is_word;
  logic        req_is_half;
  logic        err_req;
  logic [31:0] aligned_addr;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign req_is_word = req_size[1];
  assign req_is_half = (req_size == 2'b01);

  // Without the check, offending low bits are silently cleared instead
  always_comb begin
    aligned_addr = req_addr;
    if (req_is_word) begin
      aligned_addr[1:0] = 2'b00;
    end else if (req_is_half) begin
      aligned_addr[0] = 1'b0;
    end
  end

`ifdef MAU_ALIGN_CHECK_EN
  assign err_req = (req_is_half && req_addr[0]) ||
                   (req_is_word && (req_addr[1:0] != 2'b00));
`else
  assign err_req = 1'b0;
`endif

  // Big-endian lanes: offset 0 is the most significant byte
  always_comb begin
    byte_lane = mem_rdata[31:24];
    case (offset_q)
      2'd0: byte_lane = mem_rdata[31:24];
      2'd1: byte_lane = mem_rdata[23:16];
      2'd2: byte_lane = mem_rdata[15:8];
      2'd3: byte_lane = mem_rdata[7:0];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = offset_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    if (size_q[1]) begin
      load_val = mem_rdata;
    end else if (size_q[0]) begin
      load_val = {{16{signed_q & half_lane[15]}}, half_lane};
    end else begin
      load_val = {{24{signed_q & byte_lane[7]}}, byte_lane};
    end

    merge_val = mem_rdata;
    if (size_q[0]) begin
      if (offset_q[1]) begin
        merge_val[15:0] = wdata_q;
      end else begin
        merge_val[31:16] = wdata_q;
      end
    end else begin
      case (offset_q)
        2'd0: merge_val[31:24] = wdata_q[7:0];
        2'd1: merge_val[23:16] = wdata_q[7:0];
        2'd2: merge_val[15:8]  = wdata_q[7:0];
        2'd3: merge_val[7:0]   = wdata_q[7:0];
        default: merge_val = mem_rdata;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    offset_d     = offset_q;
    size_d       = size_q;
    signed_d     = signed_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          offset_d    = aligned_addr[1:0];
          size_d      = req_size;
          signed_d    = req_signed;
          we_d        = req_we;
          wdata_d     = req_wdata[15:0];
          req_ready_d = 1'b0;
          resp_err_d  = 1'b0;
          cnt_d       = 3'd0;
          if (err_req) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (req_we && req_is_word) begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
            mem_addr_d  = aligned_addr >> WORD_SHIFT;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = READ;
            mem_read_d = 1'b1;
            mem_addr_d = aligned_addr >> WORD_SHIFT;
          end
        end
      end

      // The counter's final value marks the edge where mem_rdata is valid
      READ: begin
        if (cnt_q == 3'(MEM_LATENCY)) begin
          mem_read_d = 1'b0;
          if (we_q) begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
            mem_wdata_d = merge_val;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_val;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      WRITE: begin
        state_d      = RESP;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
      end

      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      offset_q     <= 2'd0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= 16'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural latency-pipelined memory.
// Expectations follow MAU_ALIGN_CHECK_EN when it is defined.
module tb_mem_access_unit;

  localparam int MEM_LATENCY = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checkCount = 0;
  int errorCount = 0;

  mem_access_unit #(.MEM_LATENCY(MEM_LATENCY), .WORD_SHIFT(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous memory: word[i] = i*10+1, read data emerges MEM_LATENCY edges after sampling
  logic [31:0] memArray [0:255];
  logic [31:0] readPipe [0:MEM_LATENCY-1];
  bit          memInitDone = 1'b0;
  int          writeCount = 0;
  int          readEdgeCount = 0;
  logic [31:0] lastWriteAddr = 32'd0;
  logic [31:0] lastWriteData = 32'd0;

  always @(posedge clock) begin
    if (!memInitDone) begin
      for (int i = 0; i < 256; i++) memArray[i] = i * 10 + 1;
      memInitDone = 1'b1;
    end
    if (mem_read) begin
      readPipe[0] <= memArray[mem_addr[7:0]];
      readEdgeCount++;
    end
    for (int i = 1; i < MEM_LATENCY; i++) readPipe[i] <= readPipe[i-1];
    if (mem_write) begin
      memArray[mem_addr[7:0]] = mem_wdata;
      writeCount++;
      lastWriteAddr = mem_addr;
      lastWriteData = mem_wdata;
    end
  end

  assign mem_rdata = readPipe[MEM_LATENCY-1];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request with resp_ready held high and returns the response and latency
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int edges);
    int waitCycles;
    waitCycles = 0;
    while (!req_ready && waitCycles < 50) begin
      @(posedge clock); #1;
      waitCycles++;
    end
    checkOutput("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clock); #1;
    req_valid = 1'b0;
    edges = 0;
    while (!resp_valid && edges < 50) begin
      @(posedge clock); #1;
      edges++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clock); #1;
    checkOutput("resp_valid_after_handshake", {31'd0, resp_valid}, 32'd0);
    checkOutput("req_ready_after_handshake", {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          writesBefore;
  int          readsBefore;
  int          waitCycles;

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("rst_mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    $display("[TB] word load 0x0C");
    readsBefore = readEdgeCount;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, rd, er, lat);
    checkOutput("ldw_0c_rdata", rd, 32'h0000001F);
    checkOutput("ldw_0c_err", {31'd0, er}, 32'd0);
    checkOutput("ldw_0c_latency", lat, MEM_LATENCY + 1);
    checkOutput("ldw_0c_mem_addr", mem_addr, 32'd3);
    checkOutput("ldw_0c_read_cycles", readEdgeCount - readsBefore, MEM_LATENCY + 1);

    $display("[TB] misaligned word load 0x0E");
    readsBefore  = readEdgeCount;
    writesBefore = writeCount;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0E, 32'd0, rd, er, lat);
`ifdef MAU_ALIGN_CHECK_EN
    checkOutput("misalign_err", {31'd0, er}, 32'd1);
    checkOutput("misalign_rdata", rd, 32'd0);
    checkOutput("misalign_reads", readEdgeCount - readsBefore, 32'd0);
`else
    checkOutput("misalign_err", {31'd0, er}, 32'd0);
    checkOutput("misalign_rdata", rd, 32'h0000001F);
    checkOutput("misalign_mem_addr", mem_addr, 32'd3);
`endif
    checkOutput("misalign_writes", writeCount - writesBefore, 32'd0);

    $display("[TB] halfword signed load 0x0E");
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h0E, 32'd0, rd, er, lat);
    checkOutput("ldh_0e_rdata", rd, 32'h0000001F);

    $display("[TB] byte store 0xAB at 0x0D");
    writesBefore = writeCount;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0D, 32'h000000AB, rd, er, lat);
    checkOutput("stb_0d_writes", writeCount - writesBefore, 32'd1);
    checkOutput("stb_0d_waddr", lastWriteAddr, 32'd3);
    checkOutput("stb_0d_wdata", lastWriteData, 32'h00AB001F);
    checkOutput("stb_0d_rdata", rd, 32'd0);
    checkOutput("stb_0d_latency", lat, MEM_LATENCY + 2);

    applyStimulus(1'b0, 2'b00, 1'b1, 32'h0D, 32'd0, rd, er, lat);
    checkOutput("ldb_0d_signed", rd, 32'hFFFFFFAB);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0D, 32'd0, rd, er, lat);
    checkOutput("ldb_0d_unsigned", rd, 32'h000000AB);

    $display("[TB] halfword store 0x8001 at 0x0E");
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0E, 32'h00008001, rd, er, lat);
    checkOutput("sth_0e_wdata", lastWriteData, 32'h00AB8001);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, rd, er, lat);
    checkOutput("ldw_0c_merged", rd, 32'h00AB8001);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h0E, 32'd0, rd, er, lat);
    checkOutput("ldh_0e_signed_neg", rd, 32'hFFFF8001);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h0E, 32'd0, rd, er, lat);
    checkOutput("ldb_0e_signed_neg", rd, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0E, 32'd0, rd, er, lat);
    checkOutput("ldb_0e_unsigned", rd, 32'h00000080);

    $display("[TB] word store 0x12345678 at 0x20");
    writesBefore = writeCount;
    readsBefore  = readEdgeCount;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, rd, er, lat);
    checkOutput("stw_20_latency", lat, 32'd1);
    checkOutput("stw_20_writes", writeCount - writesBefore, 32'd1);
    checkOutput("stw_20_reads", readEdgeCount - readsBefore, 32'd0);
    checkOutput("stw_20_waddr", lastWriteAddr, 32'd8);
    applyStimulus(1'b0, 2'b11, 1'b1, 32'h20, 32'd0, rd, er, lat);
    checkOutput("ldw_20_size3", rd, 32'h12345678);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h21, 32'd0, rd, er, lat);
    checkOutput("ldb_21", rd, 32'h00000034);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h23, 32'd0, rd, er, lat);
    checkOutput("ldb_23", rd, 32'h00000078);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, rd, er, lat);
    checkOutput("ldh_22", rd, 32'h00005678);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h20, 32'd0, rd, er, lat);
    checkOutput("ldh_20", rd, 32'h00001234);

    $display("[TB] response stall");
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h20;
    @(posedge clock); #1;
    req_addr = 32'h14;
    waitCycles = 0;
    while (!resp_valid && waitCycles < 50) begin
      @(posedge clock); #1;
      waitCycles++;
    end
    readsBefore = readEdgeCount;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("stall_resp_rdata", resp_rdata, 32'h12345678);
      checkOutput("stall_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clock); #1;
    end
    checkOutput("stall_no_accept", readEdgeCount - readsBefore, 32'd0);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    checkOutput("stall_release_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("stall_release_ready", {31'd0, req_ready}, 32'd1);

    $display("[TB] reset during sub-word store read");
    writesBefore = writeCount;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h14;
    req_wdata  = 32'h000000EE;
    @(posedge clock); #1;
    req_valid = 1'b0;
    checkOutput("rstmid_mem_read_on", {31'd0, mem_read}, 32'd1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    checkOutput("rstmid_mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("rstmid_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstmid_no_write", writeCount - writesBefore, 32'd0);
    checkOutput("rstmid_no_resp", {31'd0, resp_valid}, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, rd, er, lat);
    checkOutput("rstmid_ldw_14", rd, 32'h00000033);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
